// File: rtl/config_bitstream_tx_if.sv
// Handshake bundle between the configuration byte initiator and its
// word source, outgoing byte sink and return (acknowledge) byte source.
interface config_bitstream_tx_if;
  logic [31:0] word_data_i;
  logic        word_valid_i;
  logic        word_ready_o;
  logic [7:0]  byte_data_o;
  logic        byte_valid_o;
  logic        byte_ready_i;
  logic [7:0]  ack_data_i;
  logic        ack_valid_i;
  logic        ack_ready_o;

  // Initiator side: consumes words and return bytes, produces protocol bytes.
  modport master (
    input  word_data_i, word_valid_i, byte_ready_i, ack_data_i, ack_valid_i,
    output word_ready_o, byte_data_o, byte_valid_o, ack_ready_o
  );

  // Environment side: word source, byte sink and acknowledge source.
  modport slave (
    output word_data_i, word_valid_i, byte_ready_i, ack_data_i, ack_valid_i,
    input  word_ready_o, byte_data_o, byte_valid_o, ack_ready_o
  );
endinterface

// File: rtl/config_bitstream_tx.sv
// Fabric configuration byte-protocol initiator: emits the sync header,
// serialises 32-bit bitstream words MSB first, and after the desync word
// waits for the 4-byte DONE acknowledge with a cycle timeout.
module config_bitstream_tx #(
  parameter logic [7:0]  MODE_BYTE      = 8'h01,
  parameter logic [31:0] DESYNC_WORD    = 32'h0010_0000,
  parameter logic [31:0] ACK_WORD       = 32'hFAB0_FABF,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  config_bitstream_tx_if.master bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_WORD_WAIT, S_WORD_SEND, S_ACK_WAIT, S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_bcnt;
  logic [31:0]      r_word;
  logic [31:0]      r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_error;

  logic        w_byte_valid;
  logic [7:0]  w_byte_data;
  logic        w_word_ready;
  logic        w_byte_hs;
  logic        w_word_hs;
  logic        w_last_byte;
  logic [31:0] w_sr_shift;
  logic        w_match;
  logic        w_timeout;
  logic        w_enter_ack;

  assign w_byte_hs   = w_byte_valid && bus.byte_ready_i;
  assign w_word_hs   = w_word_ready && bus.word_valid_i;
  assign w_last_byte = w_byte_hs && (r_bcnt == 2'd3);
  assign w_sr_shift  = {r_sr[23:0], bus.ack_data_i};
  // Match is judged on the value including the byte arriving this cycle.
  assign w_match     = (r_state == S_ACK_WAIT) && bus.ack_valid_i && (w_sr_shift == ACK_WORD);
  // A match in the same cycle as the last timeout cycle takes priority.
  assign w_timeout   = (r_state == S_ACK_WAIT) && !w_match && (r_cnt == CNT_LAST);
  assign w_enter_ack = (r_state != S_ACK_WAIT) && (w_next == S_ACK_WAIT);

  // State register; reset aborts any transfer immediately.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (start_i) w_next = S_HEADER;
      S_HEADER:    if (w_last_byte) w_next = S_WORD_WAIT;
      S_WORD_WAIT: if (w_word_hs) w_next = S_WORD_SEND;
      S_WORD_SEND: if (w_last_byte) w_next = (r_word == DESYNC_WORD) ? S_ACK_WAIT : S_WORD_WAIT;
      S_ACK_WAIT: begin
        if (w_match)        w_next = S_DONE;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state and byte counter, so a presented byte is
  // held stable for as long as it is not accepted.
  always_comb begin
    w_byte_valid = 1'b0;
    w_byte_data  = 8'h00;
    w_word_ready = 1'b0;
    busy_o       = (r_state != S_IDLE);
    done_o       = (r_state == S_DONE);
    case (r_state)
      S_HEADER: begin
        w_byte_valid = 1'b1;
        case (r_bcnt)
          2'd0:    w_byte_data = 8'h00;
          2'd1:    w_byte_data = 8'hAA;
          2'd2:    w_byte_data = 8'hFF;
          default: w_byte_data = MODE_BYTE;
        endcase
      end
      S_WORD_WAIT: w_word_ready = 1'b1;
      S_WORD_SEND: begin
        w_byte_valid = 1'b1;
        case (r_bcnt)
          2'd0:    w_byte_data = r_word[31:24];
          2'd1:    w_byte_data = r_word[23:16];
          2'd2:    w_byte_data = r_word[15:8];
          default: w_byte_data = r_word[7:0];
        endcase
      end
      default: ;
    endcase
  end

  // Byte counter, acknowledge shift register, timeout counter and sticky error.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_bcnt  <= 2'd0;
      r_sr    <= 32'h0;
      r_cnt   <= '0;
      r_error <= 1'b0;
    end else begin
      if (r_state == S_IDLE) r_bcnt <= 2'd0;
      else if (w_byte_hs)    r_bcnt <= r_bcnt + 2'd1;

      if (w_enter_ack) begin
        r_sr  <= 32'h0;
        r_cnt <= '0;
      end else if (r_state == S_ACK_WAIT) begin
        if (bus.ack_valid_i) r_sr <= w_sr_shift;
        if (!w_match)        r_cnt <= r_cnt + 1'b1;
      end

      if ((r_state == S_IDLE) && start_i) r_error <= 1'b0;
      else if (w_timeout)                 r_error <= 1'b1;
    end
  end

  // Word latch; pure data, only loaded on a word handshake.
  always_ff @(posedge clk_i) begin
    if (w_word_hs) r_word <= bus.word_data_i;
  end

  assign bus.byte_valid_o = w_byte_valid;
  assign bus.byte_data_o  = w_byte_data;
  assign bus.word_ready_o = w_word_ready;
  assign bus.ack_ready_o  = 1'b1;
  assign error_o          = r_error;

endmodule

// File: tb/tb_config_bitstream_tx.sv
// Directed bench for config_bitstream_tx: header, word serialisation,
// backpressure hold, acknowledge match, timeout and mid-transfer reset.
module tb_config_bitstream_tx;
  logic clk = 1'b0;
  logic reset_n;
  logic start;
  logic busy, done, error;
  int total = 0;
  int bad   = 0;

  config_bitstream_tx_if bus();

  config_bitstream_tx #(
    .MODE_BYTE(8'h01), .DESYNC_WORD(32'h0010_0000),
    .ACK_WORD(32'hFAB0_FABF), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .bus(bus),
    .busy_o(busy), .done_o(done), .error_o(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] words [8];
    logic [7:0]  expb [$];
    logic [7:0]  prev_data;
    bit          prev_stall;
    bit          hs_b, hs_w;
    int          nb, wi;

    reset_n = 1'b0; start = 1'b0;
    bus.word_data_i = 32'h0; bus.word_valid_i = 1'b0; bus.byte_ready_i = 1'b1;
    bus.ack_data_i = 8'h00; bus.ack_valid_i = 1'b0;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_bvalid", bus.byte_valid_o, 0);
    chk("rst_bdata", bus.byte_data_o, 8'h00);
    chk("rst_wready", bus.word_ready_o, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("ack_ready", bus.ack_ready_o, 1);
    reset_n = 1'b1;
    tick();

    // Test 1: header on consecutive handshakes
    start = 1'b1; tick(); start = 1'b0;
    chk("hdr0", bus.byte_data_o, 8'h00); chk("hdr0_v", bus.byte_valid_o, 1); chk("hdr_busy", busy, 1);
    tick(); chk("hdr1", bus.byte_data_o, 8'hAA);
    tick(); chk("hdr2", bus.byte_data_o, 8'hFF);
    tick(); chk("hdr3", bus.byte_data_o, 8'h01);
    tick(); chk("ww_ready", bus.word_ready_o, 1); chk("ww_bvalid", bus.byte_valid_o, 0);

    // Test 2: two words, the second is the desync word
    bus.word_valid_i = 1'b1; bus.word_data_i = 32'h1234_5678;
    tick(); bus.word_valid_i = 1'b0;
    chk("ws_wready", bus.word_ready_o, 0);
    chk("w0b0", bus.byte_data_o, 8'h12); tick();
    chk("w0b1", bus.byte_data_o, 8'h34); tick();
    chk("w0b2", bus.byte_data_o, 8'h56); tick();
    chk("w0b3", bus.byte_data_o, 8'h78); tick();
    chk("ww2_ready", bus.word_ready_o, 1);
    bus.word_valid_i = 1'b1; bus.word_data_i = 32'h0010_0000;
    tick(); bus.word_valid_i = 1'b0;
    chk("w1b0", bus.byte_data_o, 8'h00); tick();
    chk("w1b1", bus.byte_data_o, 8'h10); tick();
    chk("w1b2", bus.byte_data_o, 8'h00); tick();
    chk("w1b3", bus.byte_data_o, 8'h00); tick();
    chk("aw_busy", busy, 1); chk("aw_bvalid", bus.byte_valid_o, 0); chk("aw_wready", bus.word_ready_o, 0);

    // Test 4: acknowledge with a leading garbage byte
    bus.ack_valid_i = 1'b1;
    bus.ack_data_i = 8'h55; tick();
    bus.ack_data_i = 8'hFA; tick();
    bus.ack_data_i = 8'hB0; tick();
    bus.ack_data_i = 8'hFA; tick();
    chk("ack_nodone", done, 0);
    bus.ack_data_i = 8'hBF; tick();
    bus.ack_valid_i = 1'b0;
    chk("ack_done", done, 1); chk("ack_done_busy", busy, 1);
    tick();
    chk("ack_done_end", done, 0); chk("ack_idle", busy, 0); chk("ack_noerr", error, 0);

    // Test 3: random byte backpressure over 8 words
    words = '{32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hA5A5_5A5A,
              32'hFFFF_0000, 32'h0010_0001, 32'h7F80_01FE, 32'h0010_0000};
    expb = '{8'h00, 8'hAA, 8'hFF, 8'h01};
    for (int k = 0; k < 8; k++)
      for (int b = 3; b >= 0; b--) expb.push_back(8'((words[k] >> (8 * b)) & 32'hFF));
    nb = 0; wi = 0; prev_stall = 0; prev_data = 8'h00;
    start = 1'b1; tick(); start = 1'b0;
    for (int cyc = 0; cyc < 3000 && nb < 36; cyc++) begin
      bus.byte_ready_i = ($urandom_range(0, 3) != 0);
      bus.word_valid_i = (wi < 8);
      bus.word_data_i  = (wi < 8) ? words[wi] : 32'h0;
      if (prev_stall) begin
        chk("hold_valid", bus.byte_valid_o, 1);
        chk("hold_data", bus.byte_data_o, prev_data);
      end
      hs_b = bus.byte_valid_o && bus.byte_ready_i;
      hs_w = bus.word_valid_i && bus.word_ready_o;
      if (hs_b) begin
        chk("bp_byte", bus.byte_data_o, expb[nb]);
        nb++;
      end
      prev_stall = bus.byte_valid_o && !bus.byte_ready_i;
      prev_data  = bus.byte_data_o;
      tick();
      if (hs_w) wi++;
    end
    bus.word_valid_i = 1'b0; bus.byte_ready_i = 1'b1;
    chk("bp_count", nb, 36);
    chk("bp_words", wi, 8);

    // Test 5: no acknowledge -> timeout after 16 cycles in ACK_WAIT
    chk("to_busy0", busy, 1); chk("to_err0", error, 0);
    repeat (7) tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_start_ign", busy, 1); chk("busy_start_nobyte", bus.byte_valid_o, 0);
    repeat (7) tick();
    chk("to_err_pre", error, 0); chk("to_busy_pre", busy, 1);
    tick();
    chk("to_err", error, 1); chk("to_idle", busy, 0); chk("to_nodone", done, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("to_clr", error, 0); chk("to_restart_v", bus.byte_valid_o, 1); chk("to_restart_d", bus.byte_data_o, 8'h00);

    // Test 6: reset in the middle of a word
    repeat (4) tick();
    chk("r_wready", bus.word_ready_o, 1);
    bus.word_valid_i = 1'b1; bus.word_data_i = 32'hA1B2_C3D4;
    tick(); bus.word_valid_i = 1'b0;
    chk("r_b0", bus.byte_data_o, 8'hA1); tick();
    chk("r_b1", bus.byte_data_o, 8'hB2); tick();
    chk("r_b2", bus.byte_data_o, 8'hC3);
    reset_n = 1'b0; #1;
    chk("r_bvalid", bus.byte_valid_o, 0); chk("r_busy", busy, 0);
    chk("r_wready0", bus.word_ready_o, 0); chk("r_bdata", bus.byte_data_o, 8'h00);
    tick(); reset_n = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("r_restart_v", bus.byte_valid_o, 1); chk("r_restart_d", bus.byte_data_o, 8'h00);
    chk("r_restart_busy", busy, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
